digit_serial_sub: RTL



---
 rtl/digit_serial_sub.sv | 131 +++++++++++++
 1 files changed

// File: rtl/digit_serial_sub.sv
// digit_serial_sub: multi-cycle N-bit borrow-propagate subtractor.
// Computes y = a - b - bin (mod 2^N) and the borrow-out, W bits per clock.
// The operands shift right one digit per RUN cycle. The result digits shift in from the top,
// so after N/W cycles digit 0 sits in the least significant position.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operand bundle
// RUN   | one digit subtracted per cycle, borrow carried in borrow_q
// DONE  | out_valid=1, y/bout held until out_ready
module digit_serial_sub #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         bout
);

    localparam int W_SAFE = (W >= 1) ? W : 1;
    localparam int ND     = N / W_SAFE;
    localparam int CW     = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] K_LAST = CW'(ND - 1);

    // A width that does not tile N would silently drop bits, so refuse to build it.
    generate
        if ((W < 1) || (W > N) || ((N % W_SAFE) != 0)) begin : g_bad_width
            $error("digit_serial_sub: W must divide N and satisfy 1 <= W <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          borrow_q;
    logic [CW-1:0] k;

    logic [W:0]    diff;
    logic [W-1:0]  d;
    logic          borrow_next;
    logic [N-1:0]  a_shift;
    logic [N-1:0]  b_shift;
    logic [N-1:0]  y_shift;

    // One digit of borrow-propagate subtraction; the extra MSB is the borrow-out.
    assign diff        = {1'b0, a_q[W-1:0]} - {1'b0, b_q[W-1:0]} - {{W{1'b0}}, borrow_q};
    assign d           = diff[W-1:0];
    assign borrow_next = diff[W];

    // With a single digit there is nothing to shift, so the shifters collapse.
    generate
        if (ND == 1) begin : g_single
            assign a_shift = '0;
            assign b_shift = '0;
            assign y_shift = d;
        end else begin : g_multi
            assign a_shift = a_q >> W;
            assign b_shift = b_q >> W;
            assign y_shift = {d, y[N-1:W]};
        end
    endgenerate

    // Control FSM plus datapath registers; handshake flags are registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            k         <= '0;
            y         <= '0;
            bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_shift;
                    b_q      <= b_shift;
                    y        <= y_shift;
                    borrow_q <= borrow_next;
                    if (k == K_LAST) begin
                        bout      <= borrow_next;
                        k         <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
